mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
// - Memory-mapped UART transmitter on the processor data bus (MemWrite/DataAdr/WriteData), downstream of the core.
// - Core stores bytes to a TX register; block buffers them in a FIFO and serialises 8N1 on uart_tx.
// - Read path exposes status for software polling; top muxes ReadData when sel=1.
// PARAMETERS
// - BASE_ADDR  32'h0000_0800  word-aligned base; registers at +0 TXDATA, +4 STATUS, +8 BAUDDIV
// - CLK_DIV    434            reset value of BAUDDIV (clk cycles per bit)
// - FIFO_DEPTH 8              TX FIFO entries, power of 2, >=2
// PORTS
// - clk        in   1   system clock, all logic on rising edge
// - reset_n    in   1   asynchronous, active-low reset
// - MemWrite   in   1   core store strobe, sampled at clk edge
// - DataAdr    in   32  core byte address
// - WriteData  in   32  core store data
// - ReadData   out  32  register read data, combinational from DataAdr
// - sel        out  1   1 when DataAdr[31:4] matches BASE_ADDR[31:4], combinational
// - uart_tx    out  1   serial line, idle high
// BEHAVIOUR
// - Reset: uart_tx=1, FIFO empty, overflow=0, BAUDDIV=CLK_DIV, FSM=IDLE, bit/baud counters 0; ReadData/sel follow decode.
// - Write TXDATA (+0, MemWrite=1): push WriteData[7:0] if count<FIFO_DEPTH; if full, drop byte, set sticky overflow.
// - Write STATUS (+4): WriteData[3]=1 clears overflow; other bits ignored.
// - Write BAUDDIV (+8): loads WriteData[15:0]; value 0 stored as 1; takes effect at next bit boundary.
// - Writes to +12 or any other offset: no effect.
// - Read: +0 -> 0; +4 -> {28'b0, overflow, busy, empty, full}; +8 -> {16'b0, BAUDDIV}; outside window -> 0.
// - busy = (FSM != IDLE). empty = (count==0). full = (count==FIFO_DEPTH).
// - FSM: IDLE -> START when FIFO non-empty (pop, load shift reg); START -> DATA after BAUDDIV cycles;
//   DATA sends 8 bits LSB first, BAUDDIV cycles each; STOP holds 1 for BAUDDIV cycles;
//   STOP end: if non-empty pop and go START directly (no idle gap), else IDLE.
// - Latency: TXDATA write at edge N into empty FIFO -> uart_tx falls after edge N+1.
// - Frame = exactly 10*BAUDDIV cycles; uart_tx is registered (no glitches).
// - Simultaneous push and pop: both occur, count unchanged; when full, push is judged on pre-pop count (dropped).
// - FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
// - reset_n low mid-frame: frame aborted, uart_tx high immediately (async), FIFO contents lost.
// STRUCTURE
// - uart_pkg: tx_state_e {IDLE,START,DATA,STOP}, register offset constants, STATUS bit indices.
// - Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/count, same clk/reset_n.
// - Top level: address decode, register file, baud counter, bit counter, shift reg, FSM.
// TESTING (bench overrides CLK_DIV=4)
// - Reset: hold reset_n=0 -> uart_tx=1, read +4 gives 32'h2, read +8 gives 32'h4.
// - Single byte: write 32'h55 to +0 -> uart_tx 0 for 4 clks, then 1,0,1,0,1,0,1,0 (4 clks each),
//   then 1 for 4 clks; busy=1 during frame; total 40 clks.
// - Back-to-back: write 8'hA5 then 8'h3C on consecutive cycles -> second start bit follows first
//   stop bit with no gap; empty=1 after second pop.
// - Overflow: 10 writes while busy -> FIFO_DEPTH accepted; full=1; overflow=1; 9 frames total out
//   (1 in flight + 8 buffered); writing 32'h8 to +4 clears overflow.
// - Divisor change mid-frame: write 32'h2 to +8 during DATA -> current bit keeps 4 clks,
//   following bits 2 clks each.
// - Reset mid-frame: drop reset_n during DATA -> uart_tx=1 same cycle; after release, status
//   reads 32'h2 and no residual frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [3:0] OFS_TXDATA  = 4'h0;
  localparam logic [3:0] OFS_STATUS  = 4'h4;
  localparam logic [3:0] OFS_BAUDDIV = 4'h8;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // A divisor of zero would stall the bit timer forever, so it is promoted to one.
  function automatic logic [15:0] div_or_one(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Push acceptance looks at the pre-pop count, so a full FIFO drops even when popping.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file on the core data bus, TX FIFO, serialiser.
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | driving the start bit (0) for one bit period
//   DATA  | shifting out 8 data bits, LSB first
//   STOP  | driving the stop bit (1); chains straight into START if more bytes wait
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        uart_tx
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_DIV);

  logic [3:0]  ofs;
  logic        wr_tx;
  logic        wr_status;
  logic        wr_baud;

  logic        overflow;
  logic [15:0] baud_div;
  logic [3:0]  status;

  logic        fifo_pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  tx_state_e   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        bit_done;

  logic        unused_bits;
  assign unused_bits = ^{WriteData[31:16], fifo_count};

  assign ofs       = DataAdr[3:0];
  assign sel       = (DataAdr[31:4] == BASE_ADDR[31:4]);
  assign wr_tx     = MemWrite && sel && (ofs == OFS_TXDATA);
  assign wr_status = MemWrite && sel && (ofs == OFS_STATUS);
  assign wr_baud   = MemWrite && sel && (ofs == OFS_BAUDDIV);

  always_comb begin
    status            = '0;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_BUSY]  = (state != IDLE);
    status[STAT_OVF]   = overflow;
  end

  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (ofs)
        OFS_STATUS:  ReadData = {28'b0, status};
        OFS_BAUDDIV: ReadData = {16'b0, baud_div};
        default:     ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      baud_div <= DIV_RESET;
    end else begin
      if (wr_tx && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_status && WriteData[STAT_OVF]) begin
        overflow <= 1'b0;
      end
      if (wr_baud) begin
        baud_div <= div_or_one(WriteData[15:0]);
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_tx),
    .wdata   (WriteData[7:0]),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The bit timer counts down to zero; the divisor is only sampled when a new bit starts.
  assign bit_done = (baud_cnt == 16'd0);
  assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= START;
            shreg    <= fifo_rdata;
            uart_tx  <= 1'b0;
            baud_cnt <= baud_div - 16'd1;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            uart_tx  <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= '0;
            baud_cnt <= baud_div - 16'd1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= baud_div - 16'd1;
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!fifo_empty) begin
              state    <= START;
              shreg    <= fifo_rdata;
              uart_tx  <= 1'b0;
              baud_cnt <= baud_div - 16'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
